ram_arbiter: RTL and testbench

//   Two-port arbiter sharing the single-port RAM between the URISC core (port 0)
//   and a second requester (port 1: program loader / debug).

---
 rtl/ram_arbiter_if.sv | 55 +++++
 rtl/ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
interface ram_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    // Port 0 (URISC core)
    logic          m0_req;
    logic          m0_lock;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    // Port 1 (loader / debug)
    logic          m1_req;
    logic          m1_lock;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    // RAM side
    logic          CS;
    logic          WRITE;
    logic          READ;
    logic [AW-1:0] ADDRESS;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] RDATA;

    logic          lock_timeout;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  RDATA,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output CS, WRITE, READ, ADDRESS, WDATA,
        output lock_timeout
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output RDATA,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  CS, WRITE, READ, ADDRESS, WDATA,
        input  lock_timeout
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter with lock for a single-port RAM.
// All RAM controls are registered; read data returns two cycles after grant.
module ram_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    localparam int unsigned HW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          tag_q, tag_d;
    logic          rr_q, rr_d;
    logic          lock_q, lock_d;
    logic          owner_q, owner_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    logic          rd_pend_q, rd_pend_d;
    logic          rd_tag_q, rd_tag_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          hold_max;
    logic          elig0, elig1;
    logic          win, win_valid;
    logic          win_we, win_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Eligibility and winner selection; nothing issues on the forced-release edge.
    always_comb begin
        hold_max  = lock_q && (hold_q == HW'(LOCK_MAX - 1));
        elig0     = bus.m0_req && !gnt_q[0] && !(lock_q && owner_q) && !hold_max;
        elig1     = bus.m1_req && !gnt_q[1] && !(lock_q && !owner_q) && !hold_max;
        win_valid = elig0 || elig1;
        // Both eligible: the port the pointer does not name wins.
        win       = (elig0 && elig1) ? !rr_q : elig1;
        win_we    = win ? bus.m1_we    : bus.m0_we;
        win_lock  = win ? bus.m1_lock  : bus.m0_lock;
        win_addr  = win ? bus.m1_addr  : bus.m0_addr;
        win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    end

    // FSM next state, registered RAM controls, lock ownership and hold counter.
    always_comb begin
        state_d   = StIdle;
        gnt_d     = 2'b00;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tag_d     = tag_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        hold_d    = lock_q ? hold_q + HW'(1) : '0;
        timeout_d = 1'b0;

        if (hold_max) begin
            lock_d    = 1'b0;
            hold_d    = '0;
            timeout_d = 1'b1;
            rr_d      = owner_q;
        end else if (win_valid) begin
            state_d    = StIssue;
            gnt_d[win] = 1'b1;
            rd_d       = !win_we;
            wr_d       = win_we;
            addr_d     = win_addr;
            wdata_d    = win_wdata;
            tag_d      = win;
            rr_d       = win;
            if (win_lock) begin
                lock_d  = 1'b1;
                owner_d = win;
            end else begin
                // Only the owner can win while locked, so this is its release access.
                lock_d = 1'b0;
                hold_d = '0;
            end
        end
    end

    // Read return pipeline: RAM data is valid the cycle after READ; route by issue tag.
    always_comb begin
        rd_pend_d = rd_q;
        rd_tag_d  = tag_q;
        rvalid_d  = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        if (rd_pend_q) begin
            if (rd_tag_q) begin
                rvalid_d[1] = 1'b1;
                rdata1_d    = bus.RDATA;
            end else begin
                rvalid_d[0] = 1'b1;
                rdata0_d    = bus.RDATA;
            end
        end
    end

    // State registers; reset drops the bus and discards any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= 2'b00;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tag_q     <= 1'b0;
            rr_q      <= 1'b1;
            lock_q    <= 1'b0;
            owner_q   <= 1'b0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
            rvalid_q  <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tag_q     <= tag_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
            rvalid_q  <= rvalid_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.CS           = (state_q == StIssue);
    assign bus.READ         = rd_q;
    assign bus.WRITE        = wr_q;
    assign bus.ADDRESS      = addr_q;
    assign bus.WDATA        = wdata_q;
    assign bus.m0_gnt       = gnt_q[0];
    assign bus.m1_gnt       = gnt_q[1];
    assign bus.m0_rvalid    = rvalid_q[0];
    assign bus.m1_rvalid    = rvalid_q[1];
    assign bus.m0_rdata     = rdata0_q;
    assign bus.m1_rdata     = rdata1_q;
    assign bus.lock_timeout = timeout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, concurrent-port sequences and a read scoreboard.
module tb_ram_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_rv0 = 0;
    int   n_rv1 = 0;
    int   n_rd0 = 0;
    int   n_rd1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.AW(8), .DW(8)) bus ();
    ram_arbiter_if #(.AW(8), .DW(8)) lm_bus ();

    ram_arbiter #(.AW(8), .DW(8), .LOCK_MAX(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ram_arbiter #(.AW(8), .DW(8), .LOCK_MAX(4)) u_lm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lm_bus)
    );

    // Synchronous RAM model: default contents ~addr, RAM[0x10] = 0xA5.
    logic [7:0] ram [256];
    logic [7:0] ram_rdata = 8'h00;
    bit         ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= ~8'(i);
            ram[8'h10] <= 8'hA5;
            ram_ready  <= 1'b1;
        end else begin
            if (bus.CS && bus.READ) ram_rdata <= ram[bus.ADDRESS];
            if (bus.CS && bus.WRITE) ram[bus.ADDRESS] <= bus.WDATA;
        end
    end
    assign bus.RDATA    = ram_rdata;
    assign lm_bus.RDATA = 8'h00;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        int         p;
        bit         we;
        bit         lk;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    task automatic drive(input int p, input bit r, input bit we, input bit lk,
                         input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_lock = lk;
            bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_lock = lk;
            bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    // One access: request, wait for grant, check the bus, queue the expected read,
    // then drop the request one edge after the grant.
    task automatic access(input int p, input bit we, input bit lk, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] x, output int gc);
        bit   got;
        int   n;
        exp_t e;
        got = 1'b0;
        n   = 0;
        gc  = -1;
        drive(p, 1'b1, we, lk, a, d);
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = (p == 0) ? bus.m0_gnt : bus.m1_gnt;
        end
        chk($sformatf("m%0d gnt within bound", p), 32'(got), 1);
        if (got) begin
            gc = cyc;
            chk($sformatf("m%0d CS at gnt", p), 32'(bus.CS), 1);
            chk($sformatf("m%0d ADDRESS at gnt", p), 32'(bus.ADDRESS), 32'(a));
            chk($sformatf("m%0d READ at gnt", p), 32'(bus.READ), 32'(!we));
            chk($sformatf("m%0d WRITE at gnt", p), 32'(bus.WRITE), 32'(we));
            if (we) begin
                chk($sformatf("m%0d WDATA at gnt", p), 32'(bus.WDATA), 32'(d));
            end else begin
                e.data = x;
                e.cyc  = cyc + 2;
                if (p == 0) begin q0.push_back(e); n_rd0++; end
                else begin q1.push_back(e); n_rd1++; end
            end
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 1'b0, a, d);
    endtask

    // Response monitor: every rvalid pops its port's queue; data and latency checked.
    always @(negedge clk) begin
        exp_t e;
        if (bus.m0_rvalid) begin
            n_rv0++;
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL m0 rvalid: got unexpected pulse rdata=0x%0h, want none",
                         bus.m0_rdata);
            end else begin
                e = q0.pop_front();
                chk("m0 rdata", 32'(bus.m0_rdata), 32'(e.data));
                chk("m0 rvalid cycle", cyc, e.cyc);
            end
        end
        if (bus.m1_rvalid) begin
            n_rv1++;
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL m1 rvalid: got unexpected pulse rdata=0x%0h, want none",
                         bus.m1_rdata);
            end else begin
                e = q1.pop_front();
                chk("m1 rdata", 32'(bus.m1_rdata), 32'(e.data));
                chk("m1 rvalid cycle", cyc, e.cyc);
            end
        end
        if (bus.m0_gnt && bus.m1_gnt) begin
            n_chk++;
            $display("FAIL dual gnt: got both ports granted at cycle %0d, want one", cyc);
        end
    end

    initial begin
        vec_t       tbl[7];
        int         gc;
        int         g0s[4];
        int         g1s[4];
        int         lg0, lgt, lg1, nto;
        int         gr0, gr1, gw, gm1;
        int         ga, gb, nrv;
        bit         got6;
        logic [7:0] a0, a1;

        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        lm_bus.m0_req = 1'b0; lm_bus.m0_lock = 1'b0; lm_bus.m0_we = 1'b0;
        lm_bus.m0_addr = 8'h00; lm_bus.m0_wdata = 8'h00;
        lm_bus.m1_req = 1'b0; lm_bus.m1_lock = 1'b0; lm_bus.m1_we = 1'b0;
        lm_bus.m1_addr = 8'h00; lm_bus.m1_wdata = 8'h00;

        tbl[0] = '{0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};  // preloaded value
        tbl[1] = '{1, 1'b1, 1'b0, 8'h40, 8'h5A, 8'h00};
        tbl[2] = '{0, 1'b0, 1'b0, 8'h40, 8'h00, 8'h5A};  // sees m1's write
        tbl[3] = '{1, 1'b0, 1'b0, 8'h41, 8'h00, 8'hBE};
        tbl[4] = '{0, 1'b1, 1'b0, 8'hFF, 8'h01, 8'h00};  // top address
        tbl[5] = '{1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h01};
        tbl[6] = '{0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};  // bottom address

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst CS", 32'(bus.CS), 0);
        chk("rst READ", 32'(bus.READ), 0);
        chk("rst WRITE", 32'(bus.WRITE), 0);
        chk("rst ADDRESS", 32'(bus.ADDRESS), 0);
        chk("rst WDATA", 32'(bus.WDATA), 0);
        chk("rst m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rst m1_gnt", 32'(bus.m1_gnt), 0);
        chk("rst m0_rvalid", 32'(bus.m0_rvalid), 0);
        chk("rst m0_rdata", 32'(bus.m0_rdata), 0);
        chk("rst lock_timeout", 32'(bus.lock_timeout), 0);
        rst_n = 1'b1;

        // Forced lock release on the LOCK_MAX=4 instance
        @(posedge clk);
        #1;
        lm_bus.m0_req = 1'b1; lm_bus.m0_lock = 1'b1; lm_bus.m0_addr = 8'h05;
        lm_bus.m1_req = 1'b1; lm_bus.m1_addr = 8'h06;
        lg0 = -1; lgt = -1; lg1 = -1; nto = 0;
        for (int i = 0; i < 30 && lg1 < 0; i++) begin
            @(negedge clk);
            if (lm_bus.m0_gnt) begin
                if (lg0 < 0) lg0 = cyc;
                lm_bus.m0_req = 1'b0;
                lm_bus.m0_lock = 1'b0;
            end
            if (lm_bus.lock_timeout) begin
                nto++;
                if (lgt < 0) lgt = cyc;
            end
            if (lm_bus.m1_gnt) begin
                lg1 = cyc;
                lm_bus.m1_req = 1'b0;
            end
        end
        chk("lm m0 granted first", 32'(lg0 >= 0 && (lg1 < 0 || lg0 < lg1)), 1);
        chk("lm timeout after 4 owned cycles", lgt - lg0, 4);
        chk("lm m1 gnt right after timeout", lg1 - lgt, 1);
        chk("lm timeout pulse width", nto, 1);

        // Table of single-port accesses
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            access(tbl[i].p, tbl[i].we, tbl[i].lk, tbl[i].addr, tbl[i].wdata, tbl[i].exp, gc);
        end

        // Both ports held: strict alternation, one access every cycle
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    a0 = 8'(8'h30 + i);
                    access(0, 1'b0, 1'b0, a0, 8'h00, ~a0, g0s[i]);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    a1 = 8'(8'h50 + j);
                    access(1, 1'b0, 1'b0, a1, 8'h00, ~a1, g1s[j]);
                end
            end
        join
        for (int i = 0; i < 3; i++) begin
            chk("m0 back-to-back spacing", g0s[i + 1] - g0s[i], 2);
            chk("m1 back-to-back spacing", g1s[i + 1] - g1s[i], 2);
        end
        chk("ports interleave", (g0s[0] > g1s[0]) ? g0s[0] - g1s[0] : g1s[0] - g0s[0], 1);

        // Locked read-read-write by m0 while m1 waits
        fork
            begin
                access(0, 1'b0, 1'b1, 8'h20, 8'h00, 8'hDF, gr0);
                access(0, 1'b0, 1'b1, 8'h21, 8'h00, 8'hDE, gr1);
                access(0, 1'b1, 1'b0, 8'h21, 8'h33, 8'h00, gw);
            end
            begin
                @(posedge clk);
                #1;
                access(1, 1'b0, 1'b0, 8'h21, 8'h00, 8'h33, gm1);
            end
        join
        chk("locked m0 second read", gr1 - gr0, 2);
        chk("locked m0 write", gw - gr1, 2);
        chk("m1 gnt right after release", gm1 - gw, 1);

        // Reset during an m0 read issue
        repeat (4) @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        got6 = 1'b0;
        for (int i = 0; i < 20 && !got6; i++) begin
            @(negedge clk);
            got6 = bus.m0_gnt;
        end
        chk("rst-test m0 gnt", 32'(got6), 1);
        rst_n = 1'b0;
        #1;
        chk("mid-access rst CS", 32'(bus.CS), 0);
        chk("mid-access rst READ", 32'(bus.READ), 0);
        chk("mid-access rst m0_gnt", 32'(bus.m0_gnt), 0);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nrv = n_rv0;
        repeat (5) @(negedge clk);
        chk("no m0_rvalid after reset", n_rv0 - nrv, 0);
        @(posedge clk);
        #1;
        fork
            access(0, 1'b0, 1'b0, 8'h11, 8'h00, 8'hEE, ga);
            access(1, 1'b0, 1'b0, 8'h12, 8'h00, 8'hED, gb);
        join
        chk("post-reset port 0 wins first", gb - ga, 1);

        repeat (6) @(negedge clk);
        chk("m0 read responses", n_rv0, n_rd0);
        chk("m1 read responses", n_rv1, n_rd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
